weight_batch_serializer: RTL and testbench

- Transmit side of the candidate-weight interface consumed by the error/best-weight tracker.
- Accepts one full candidate vector of Num_Unknowns extended-float elements through a valid/ready handshake.
- Emits the vector as successive batches of Num_Unknown_Per_Batch elements, one batch per clock.
- Then holds off until the evaluator returns the error for that candidate, or a timeout expires.

---
 rtl/weight_batch_serializer.sv | 135 +++++++++++++
 tb/tb_weight_batch_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_batch_serializer.sv
// weight_batch_serializer: takes one candidate weight vector over a valid/ready
// handshake and emits it as back-to-back batches, one batch per clock. It then
// waits for the evaluator's error or a timeout before taking the next vector.
// Each element is {exception flags, payload}. Elements flagged as zero (00) get
// a cleared payload when the vector is captured.
module weight_batch_serializer #(
  parameter int ELEMENT_WIDTH         = 32,
  parameter int Extra                 = 2,
  parameter int Num_Unknowns          = 2,
  parameter int Num_Unknown_Per_Batch = 1,
  parameter int ERR_TIMEOUT           = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [(ELEMENT_WIDTH+Extra)*Num_Unknowns-1:0]     in_weights,
  output logic                                              out_valid,
  output logic                                              out_first,
  output logic                                              out_last,
  output logic [(ELEMENT_WIDTH+Extra)*Num_Unknown_Per_Batch-1:0] out_weights,
  input  logic                                              err_valid,
  input  logic [ELEMENT_WIDTH+Extra-1:0]                    err_in,
  output logic [ELEMENT_WIDTH+Extra-1:0]                    err_out,
  output logic                                              done,
  output logic                                              timeout
);

  localparam int EW      = ELEMENT_WIDTH + Extra;
  localparam int VEC_W   = EW * Num_Unknowns;
  localparam int BATCH_W = EW * Num_Unknown_Per_Batch;
  localparam int NB      = Num_Unknowns / Num_Unknown_Per_Batch;
  localparam int CNT_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO_W   = (ERR_TIMEOUT > 1) ? $clog2(ERR_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(NB - 1);
  localparam logic [TMO_W-1:0] LAST_TMO   = TMO_W'(ERR_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ERR} state_t;

  state_t             state;
  logic [VEC_W-1:0]   shift_buf;
  logic [CNT_W-1:0]   batch_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [VEC_W-1:0]   canon_vec;

  // Clear the payload of every element whose exception flags say "zero",
  // so downstream never sees a signed zero or stray payload bits.
  function automatic logic [VEC_W-1:0] canon_zero(input logic [VEC_W-1:0] v);
    logic [VEC_W-1:0] r;
    r = v;
    for (int i = 0; i < Num_Unknowns; i++) begin
      if (v[i*EW+ELEMENT_WIDTH +: Extra] == '0)
        r[i*EW +: ELEMENT_WIDTH] = '0;
    end
    return r;
  endfunction

  // Canonicalized view of the incoming vector, used only at capture.
  always_comb begin
    canon_vec = canon_zero(in_weights);
  end

  // Control FSM and all registered outputs. The first beat is loaded straight
  // from the captured vector; shift_buf holds the batches not yet sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_weights <= '0;
      err_out     <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      shift_buf   <= '0;
      batch_cnt   <= '0;
      tmo_cnt     <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            out_weights <= canon_vec[VEC_W-1 -: BATCH_W];
            shift_buf   <= canon_vec << BATCH_W;
            batch_cnt   <= '0;
            out_valid   <= 1'b1;
            out_first   <= 1'b1;
            out_last    <= (NB == 1);
            in_ready    <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (batch_cnt == LAST_BATCH) begin
            // Last beat is on the bus now; out_weights keeps holding it.
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            tmo_cnt   <= '0;
            state     <= WAIT_ERR;
          end else begin
            out_weights <= shift_buf[VEC_W-1 -: BATCH_W];
            shift_buf   <= shift_buf << BATCH_W;
            batch_cnt   <= CNT_W'(batch_cnt + 1'b1);
            out_first   <= 1'b0;
            out_last    <= (CNT_W'(batch_cnt + 1'b1) == LAST_BATCH);
          end
        end
        WAIT_ERR: begin
          // A returned error takes priority over a timeout expiring the same cycle.
          if (err_valid) begin
            err_out  <= err_in;
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else if (tmo_cnt == LAST_TMO) begin
            timeout  <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_batch_serializer.sv
// Directed bench for weight_batch_serializer: a default build (one element per
// beat) and a two-element-per-beat build, sharing clock and reset.
module tb_weight_batch_serializer;

  localparam int EW = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default build: two elements, one per beat
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_first, a_out_last;
  logic [2*EW-1:0] a_in_weights;
  logic [EW-1:0] a_out_weights, a_err_in, a_err_out;
  logic          a_err_valid, a_done, a_timeout;

  // Wide build: two elements in a single beat
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_first, b_out_last;
  logic [2*EW-1:0] b_in_weights, b_out_weights;
  logic [EW-1:0] b_err_in, b_err_out;
  logic          b_err_valid, b_done, b_timeout;

  weight_batch_serializer u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_weights(a_in_weights),
    .out_valid(a_out_valid), .out_first(a_out_first), .out_last(a_out_last),
    .out_weights(a_out_weights),
    .err_valid(a_err_valid), .err_in(a_err_in), .err_out(a_err_out),
    .done(a_done), .timeout(a_timeout)
  );

  weight_batch_serializer #(.Num_Unknown_Per_Batch(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_weights(b_in_weights),
    .out_valid(b_out_valid), .out_first(b_out_first), .out_last(b_out_last),
    .out_weights(b_out_weights),
    .err_valid(b_err_valid), .err_in(b_err_in), .err_out(b_err_out),
    .done(b_done), .timeout(b_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [2*EW-1:0] obs,
                           input logic [2*EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    a_in_valid = 0; a_in_weights = '0; a_err_valid = 0; a_err_in = '0;
    b_in_valid = 0; b_in_weights = '0; b_err_valid = 0; b_err_in = '0;

    // 1. Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_val("rst_in_ready", 68'(a_in_ready), 68'd1);
    check_val("rst_out_valid", 68'(a_out_valid), 68'd0);
    check_val("rst_err_out", 68'(a_err_out), 68'd0);
    check_val("rst_out_weights", 68'(a_out_weights), 68'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= a_done | a_timeout | b_done | b_timeout | a_out_valid;
    end
    check_val("idle_no_pulses", 68'(seen), 68'd0);

    // 2. Normal vector, error returned two cycles after the last beat
    a_in_weights = {2'b01, 32'h40a75c29, 2'b01, 32'hbea4dd2f};
    a_in_valid = 1;
    step();
    a_in_valid = 0;
    check_val("t2_b1_valid", 68'(a_out_valid), 68'd1);
    check_val("t2_b1_data", 68'(a_out_weights), 68'({2'b01, 32'h40a75c29}));
    check_val("t2_b1_first", 68'(a_out_first), 68'd1);
    check_val("t2_b1_last", 68'(a_out_last), 68'd0);
    check_val("t2_b1_in_ready", 68'(a_in_ready), 68'd0);
    step();
    check_val("t2_b2_valid", 68'(a_out_valid), 68'd1);
    check_val("t2_b2_data", 68'(a_out_weights), 68'({2'b01, 32'hbea4dd2f}));
    check_val("t2_b2_first", 68'(a_out_first), 68'd0);
    check_val("t2_b2_last", 68'(a_out_last), 68'd1);
    step();
    check_val("t2_wait_valid", 68'(a_out_valid), 68'd0);
    check_val("t2_wait_hold", 68'(a_out_weights), 68'({2'b01, 32'hbea4dd2f}));
    step();
    a_err_in = {2'b01, 32'hc0000000};
    a_err_valid = 1;
    step();
    a_err_valid = 0;
    check_val("t2_done", 68'(a_done), 68'd1);
    check_val("t2_err_out", 68'(a_err_out), 68'({2'b01, 32'hc0000000}));
    check_val("t2_in_ready", 68'(a_in_ready), 68'd1);
    step();
    check_val("t2_done_pulse", 68'(a_done), 68'd0);

    // 3. Zero canonicalization of element 0
    a_in_weights = {2'b00, 32'h3f07ae14, 2'b01, 32'hc09d0e56};
    a_in_valid = 1;
    step();
    a_in_valid = 0;
    check_val("t3_b1_data", 68'(a_out_weights), 68'd0);
    check_val("t3_b1_first", 68'(a_out_first), 68'd1);
    step();
    check_val("t3_b2_data", 68'(a_out_weights), 68'({2'b01, 32'hc09d0e56}));
    check_val("t3_b2_last", 68'(a_out_last), 68'd1);
    step();
    a_err_in = {2'b01, 32'h3f800000};
    a_err_valid = 1;
    step();
    a_err_valid = 0;
    check_val("t3_done", 68'(a_done), 68'd1);
    check_val("t3_err_out", 68'(a_err_out), 68'({2'b01, 32'h3f800000}));

    // 4. No error returned: timeout 16 cycles after entering WAIT_ERR
    step();
    a_in_weights = {2'b01, 32'h11223344, 2'b01, 32'h55667788};
    a_in_valid = 1;
    step();                       // beat 1
    a_in_valid = 0;
    step();                       // beat 2
    step();                       // WAIT_ERR entered on this edge
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen |= a_timeout | a_done;
    end
    check_val("t4_no_early_timeout", 68'(seen), 68'd0);
    step();
    check_val("t4_timeout", 68'(a_timeout), 68'd1);
    check_val("t4_no_done", 68'(a_done), 68'd0);
    check_val("t4_err_kept", 68'(a_err_out), 68'({2'b01, 32'h3f800000}));
    check_val("t4_in_ready", 68'(a_in_ready), 68'd1);
    step();
    check_val("t4_timeout_pulse", 68'(a_timeout), 68'd0);

    // 5. Wide build: stray error in IDLE, then a single first+last beat
    b_err_in = {2'b00, 32'h3f07ae14};
    b_err_valid = 1;
    step();
    b_err_valid = 0;
    check_val("t5_stray_err_out", 68'(b_err_out), 68'd0);
    check_val("t5_stray_done", 68'(b_done), 68'd0);
    b_in_weights = {2'b01, 32'hc0a75c29, 2'b01, 32'hbea4dd2f};
    b_in_valid = 1;
    step();
    b_in_valid = 0;
    check_val("t5_valid", 68'(b_out_valid), 68'd1);
    check_val("t5_data", b_out_weights, {2'b01, 32'hc0a75c29, 2'b01, 32'hbea4dd2f});
    check_val("t5_first", 68'(b_out_first), 68'd1);
    check_val("t5_last", 68'(b_out_last), 68'd1);
    step();
    check_val("t5_after_valid", 68'(b_out_valid), 68'd0);
    b_err_in = {2'b01, 32'h11111111};
    b_err_valid = 1;
    step();
    b_err_valid = 0;
    check_val("t5_done", 68'(b_done), 68'd1);
    check_val("t5_err_out", 68'(b_err_out), 68'({2'b01, 32'h11111111}));
    step();
    b_err_in = {2'b00, 32'h3f07ae14};
    b_err_valid = 1;
    step();
    b_err_valid = 0;
    check_val("t5_stray2_err_out", 68'(b_err_out), 68'({2'b01, 32'h11111111}));
    check_val("t5_stray2_done", 68'(b_done), 68'd0);

    // 6. Reset during beat 1 aborts the vector
    a_in_weights = {2'b01, 32'h40a75c29, 2'b01, 32'hbea4dd2f};
    a_in_valid = 1;
    step();
    a_in_valid = 0;
    check_val("t6_beat1_valid", 68'(a_out_valid), 68'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_async_valid", 68'(a_out_valid), 68'd0);
    check_val("t6_async_ready", 68'(a_in_ready), 68'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= a_out_valid | a_done | a_timeout;
    end
    check_val("t6_no_activity", 68'(seen), 68'd0);
    check_val("t6_in_ready", 68'(a_in_ready), 68'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
